// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard-control bundle between the pipeline and its stall/flush sequencer
//   master (pipeline side): drives id_instr/id_valid/ex_instr/ex_valid/ex_br_taken,
//                           receives pc_en/ifid_en/ifid_flush/idex_en/idex_flush/exmem_bubble/busy
//   slave  (controller)   : the reverse directions
interface pipeline_hazard_ctrl_if;
    logic [15:0] id_instr;
    logic        id_valid;
    logic [15:0] ex_instr;
    logic        ex_valid;
    logic        ex_br_taken;
    logic        pc_en;
    logic        ifid_en;
    logic        ifid_flush;
    logic        idex_en;
    logic        idex_flush;
    logic        exmem_bubble;
    logic        busy;
    modport master (
        output id_instr, id_valid, ex_instr, ex_valid, ex_br_taken,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_bubble, busy
    );
    modport slave (
        input  id_instr, id_valid, ex_instr, ex_valid, ex_br_taken,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_bubble, busy
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 16-bit 5-stage pipeline (load-use, MUL/DIV, taken branch)
//   clk            : clock
//   rst            : asynchronous reset, active-low
//   hz (slave)     : IF/ID and ID/EX instructions, branch resolution in; PC/IF-ID/ID-EX/EX-MEM controls out
//   o_stall_cycles : saturating count of cycles with pc_en=0 (only with HAZ_PERF_CNT_EN)
//   o_flush_events : saturating count of cycles with ifid_flush=1 (only with HAZ_PERF_CNT_EN)
// Optional feature macro: HAZ_PERF_CNT_EN
module pipeline_hazard_ctrl #(
    parameter logic [3:0] OPC_LOAD = 4'hA,
    parameter logic [3:0] OPC_MUL  = 4'h8,
    parameter logic [3:0] OPC_DIV  = 4'h9,
    parameter int         MUL_LAT  = 4,
    parameter int         DIV_LAT  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef HAZ_PERF_CNT_EN
    pipeline_hazard_ctrl_if.slave hz,
    output logic [31:0]           o_stall_cycles,
    output logic [31:0]           o_flush_events
`else
    pipeline_hazard_ctrl_if.slave hz
`endif
);
    typedef enum logic [1:0] {RUN, LDSTALL, MCWAIT} state_t;
    // The first held cycle is spent in RUN, so MCWAIT starts counting at LAT-2.
    localparam logic [7:0] MUL_CNT = 8'(MUL_LAT - 2);
    localparam logic [7:0] DIV_CNT = 8'(DIV_LAT - 2);
    state_t     r_state, w_next;
    logic [7:0] r_cnt, w_cnt_next;
    logic       w_lu, w_mc;
    logic       w_pc_en, w_ifid_en, w_ifid_flush, w_idex_en, w_idex_flush, w_exmem_bubble;
    assign w_lu = hz.ex_valid && hz.ex_instr[15:12] == OPC_LOAD && hz.id_valid &&
                  (hz.id_instr[7:4] == hz.ex_instr[11:8] || hz.id_instr[3:0] == hz.ex_instr[11:8]);
    assign w_mc = hz.ex_valid && (hz.ex_instr[15:12] == OPC_MUL || hz.ex_instr[15:12] == OPC_DIV);
    always_comb begin
        w_pc_en        = 1'b1;
        w_ifid_en      = 1'b1;
        w_ifid_flush   = 1'b0;
        w_idex_en      = 1'b1;
        w_idex_flush   = 1'b0;
        w_exmem_bubble = 1'b0;
        w_next         = r_state;
        w_cnt_next     = r_cnt;
        if (!rst) begin
            w_pc_en        = 1'b0;
            w_ifid_en      = 1'b0;
            w_idex_en      = 1'b0;
            w_ifid_flush   = 1'b1;
            w_idex_flush   = 1'b1;
            w_exmem_bubble = 1'b1;
            w_next         = RUN;
            w_cnt_next     = 8'd0;
        end else begin
            case (r_state)
                RUN: begin
                    if (hz.ex_br_taken) begin
                        w_ifid_flush = 1'b1;
                        w_idex_flush = 1'b1;
                    end else if (w_mc) begin
                        w_pc_en        = 1'b0;
                        w_ifid_en      = 1'b0;
                        w_idex_en      = 1'b0;
                        w_exmem_bubble = 1'b1;
                        w_cnt_next     = hz.ex_instr[15:12] == OPC_DIV ? DIV_CNT : MUL_CNT;
                        w_next         = MCWAIT;
                    end else if (w_lu) begin
                        w_pc_en      = 1'b0;
                        w_ifid_en    = 1'b0;
                        w_idex_flush = 1'b1;
                        w_next       = LDSTALL;
                    end
                end
                LDSTALL: w_next = RUN;
                MCWAIT: begin
                    // Branch and load-use inputs are ignored until the release cycle hands back to RUN.
                    if (r_cnt != 8'd0) begin
                        w_pc_en        = 1'b0;
                        w_ifid_en      = 1'b0;
                        w_idex_en      = 1'b0;
                        w_exmem_bubble = 1'b1;
                        w_cnt_next     = r_cnt - 8'd1;
                    end else begin
                        w_next = RUN;
                    end
                end
                default: w_next = RUN;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RUN;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end
    assign hz.pc_en        = w_pc_en;
    assign hz.ifid_en      = w_ifid_en;
    assign hz.ifid_flush   = w_ifid_flush;
    assign hz.idex_en      = w_idex_en;
    assign hz.idex_flush   = w_idex_flush;
    assign hz.exmem_bubble = w_exmem_bubble;
    assign hz.busy         = rst && r_state != RUN;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] r_stall_cycles, r_flush_events;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= 32'd0;
            r_flush_events <= 32'd0;
        end else begin
            if (!w_pc_en && r_stall_cycles != 32'hFFFF_FFFF) r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_ifid_flush && r_flush_events != 32'hFFFF_FFFF) r_flush_events <= r_flush_events + 32'd1;
        end
    end
    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_events = r_flush_events;
`endif
endmodule
